// File: rtl/ctrl_sequencer.sv
// Hardwired control sequencer: fetch (T0-T3), decode (T4), execute (T5-T7).
// Define MULDIV_EN to add the MUL (15) and DIV (16) execute sequences.
module ctrl_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCin,
  output logic        PCout,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [3:0]  ALUop,
  output logic        ALU_MUL,
  output logic        ALU_DIV,
  output logic        halted,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_NOP = 5'd26;

  state_t     cur;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu;
  logic       is_md;
  logic       is_mul;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];
  assign is_alu    = (opcode <= 5'd8);
  assign is_mul    = (opcode == 5'd15);
`ifdef MULDIV_EN
  assign is_md     = is_mul || (opcode == 5'd16);
`else
  assign is_md     = 1'b0;
`endif

  assign state  = cur;
  assign halted = (cur == S_HALT);

  always_ff @(posedge clock) begin
    if (clear) begin
      cur <= S_IDLE;
    end else begin
      case (cur)
        S_IDLE: cur <= run ? S_T0 : S_IDLE;
        S_T0:   cur <= S_T1;
        S_T1:   cur <= S_T2;
        S_T2:   cur <= mem_ready ? S_T3 : S_T2;
        S_T3:   cur <= S_T4;
        S_T4: begin
          if (is_alu || is_md)
            cur <= S_T5;
          else if (opcode == OP_NOP)
            cur <= run ? S_T0 : S_IDLE;
          else
            cur <= S_HALT;
        end
        S_T5:   cur <= S_T6;
        S_T6: begin
          if (is_md)
            cur <= S_T7;
          else
            cur <= run ? S_T0 : S_IDLE;
        end
        S_T7:   cur <= run ? S_T0 : S_IDLE;
        S_HALT: cur <= S_HALT;
        default: cur <= S_IDLE;
      endcase
    end
  end

  // Moore decode: strobes depend on state and the latched IR only
  always_comb begin
    Rin      = 16'h0000;
    Rout     = 16'h0000;
    PCin     = 1'b0;
    PCout    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    ALUop    = 4'h0;
    ALU_MUL  = 1'b0;
    ALU_DIV  = 1'b0;
    case (cur)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
      end
      S_T2: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T3: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T4: begin
        if (is_alu) begin
          Rout = 16'h0001 << rb;
          Yin  = 1'b1;
        end
`ifdef MULDIV_EN
        else if (is_md) begin
          Rout = 16'h0001 << ra;
          Yin  = 1'b1;
        end
`endif
      end
      S_T5: begin
        if (is_alu) begin
          Rout   = 16'h0001 << rc;
          Zlowin = 1'b1;
          ALUop  = opcode[3:0];
        end
`ifdef MULDIV_EN
        else if (is_md) begin
          Rout    = 16'h0001 << rb;
          ALU_MUL = is_mul;
          ALU_DIV = !is_mul;
          Zlowin  = 1'b1;
          Zhighin = 1'b1;
        end
`endif
      end
      S_T6: begin
        if (is_alu) begin
          Zlowout = 1'b1;
          Rin     = 16'h0001 << ra;
        end
`ifdef MULDIV_EN
        else if (is_md) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
        end
`endif
      end
      S_T7: begin
`ifdef MULDIV_EN
        Zhighout = 1'b1;
        HIin     = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed testbench for ctrl_sequencer.
// Observes state, all strobes, Rin, Rout and ALUop as one vector.
module tb_ctrl_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        run = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        mem_ready = 1'b1;
  logic [15:0] Rin, Rout;
  logic        PCin, PCout, MARin, MDRin, MDRout, IRin, Yin;
  logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
  logic        IncPC, Read, ALU_MUL, ALU_DIV, halted;
  logic [3:0]  ALUop, state;

  int n_vec = 0;
  int n_bad = 0;

  ctrl_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .IR(IR),
    .mem_ready(mem_ready), .Rin(Rin), .Rout(Rout),
    .PCin(PCin), .PCout(PCout), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
    .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .ALUop(ALUop), .ALU_MUL(ALU_MUL), .ALU_DIV(ALU_DIV),
    .halted(halted), .state(state)
  );

  always #5 clock = ~clock;

  localparam logic [17:0] B_PCIN  = 18'd1 << 17;
  localparam logic [17:0] B_PCOUT = 18'd1 << 16;
  localparam logic [17:0] B_MARIN = 18'd1 << 15;
  localparam logic [17:0] B_MDRIN = 18'd1 << 14;
  localparam logic [17:0] B_MDROUT= 18'd1 << 13;
  localparam logic [17:0] B_IRIN  = 18'd1 << 12;
  localparam logic [17:0] B_YIN   = 18'd1 << 11;
  localparam logic [17:0] B_ZLIN  = 18'd1 << 10;
  localparam logic [17:0] B_ZHIN  = 18'd1 << 9;
  localparam logic [17:0] B_ZLOUT = 18'd1 << 8;
  localparam logic [17:0] B_ZHOUT = 18'd1 << 7;
  localparam logic [17:0] B_HIIN  = 18'd1 << 6;
  localparam logic [17:0] B_LOIN  = 18'd1 << 5;
  localparam logic [17:0] B_INCPC = 18'd1 << 4;
  localparam logic [17:0] B_READ  = 18'd1 << 3;
  localparam logic [17:0] B_MUL   = 18'd1 << 2;
  localparam logic [17:0] B_DIV   = 18'd1 << 1;
  localparam logic [17:0] B_HALT  = 18'd1 << 0;

  localparam logic [17:0] F_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZLIN;
  localparam logic [17:0] F_T1 = B_ZLOUT | B_PCIN;
  localparam logic [17:0] F_T2 = B_READ | B_MDRIN;
  localparam logic [17:0] F_T3 = B_MDROUT | B_IRIN;

  logic [17:0] sb;
  logic [57:0] obs;
  assign sb = {PCin, PCout, MARin, MDRin, MDRout, IRin, Yin,
               Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
               IncPC, Read, ALU_MUL, ALU_DIV, halted};
  assign obs = {state, sb, Rin, Rout, ALUop};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [57:0] e;
    clear = 1'b1;
    run = 1'b1;
    tick();
    tick();
    e = {4'd0, 18'h0, 16'h0, 16'h0, 4'h0};
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", obs, e);
    end
    clear = 1'b0;
    run = 1'b0;
    tick();
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL idle_hold: got %h want %h", obs, e);
    end
  endtask

  task automatic test_shl();
    logic [57:0] e [8];
    e[0] = {4'd1, F_T0, 16'h0, 16'h0, 4'h0};
    e[1] = {4'd2, F_T1, 16'h0, 16'h0, 4'h0};
    e[2] = {4'd3, F_T2, 16'h0, 16'h0, 4'h0};
    e[3] = {4'd4, F_T3, 16'h0, 16'h0, 4'h0};
    e[4] = {4'd5, B_YIN, 16'h0, 16'h0001, 4'h0};
    e[5] = {4'd6, B_ZLIN, 16'h0, 16'h0010, 4'h7};
    e[6] = {4'd7, B_ZLOUT, 16'h0080, 16'h0, 4'h0};
    e[7] = {4'd1, F_T0, 16'h0, 16'h0, 4'h0};
    IR = 32'h3B82_0000;
    mem_ready = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL shl_c%0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [57:0] e;
    mem_ready = 1'b0;
    IR = 32'hD000_0000;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      e = {4'd3, F_T2, 16'h0, 16'h0, 4'h0};
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL t2_wait%0d: got %h want %h", i, obs, e);
      end
      if (i == 3)
        mem_ready = 1'b1;
    end
    tick();
    e = {4'd4, F_T3, 16'h0, 16'h0, 4'h0};
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL t3_after_wait: got %h want %h", obs, e);
    end
    tick();
    run = 1'b0;
    e = {4'd5, 18'h0, 16'h0, 16'h0, 4'h0};
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL nop_t4: got %h want %h", obs, e);
    end
    tick();
    e = {4'd0, 18'h0, 16'h0, 16'h0, 4'h0};
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL nop_idle: got %h want %h", obs, e);
    end
  endtask

  task automatic test_halt();
    logic [57:0] e;
    IR = 32'hD800_0000;
    run = 1'b1;
    for (int i = 0; i < 5; i++)
      tick();
    e = {4'd5, 18'h0, 16'h0, 16'h0, 4'h0};
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL halt_t4: got %h want %h", obs, e);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      e = {4'd9, B_HALT, 16'h0, 16'h0, 4'h0};
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL halt_hold%0d: got %h want %h", i, obs, e);
      end
    end
    clear = 1'b1;
    tick();
    e = {4'd0, 18'h0, 16'h0, 16'h0, 4'h0};
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL halt_clear: got %h want %h", obs, e);
    end
    clear = 1'b0;
  endtask

  task automatic test_clear_mid();
    logic [57:0] e;
    IR = 32'h3B82_0000;
    run = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++)
      tick();
    e = {4'd6, B_ZLIN, 16'h0, 16'h0010, 4'h7};
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL pre_clear_t5: got %h want %h", obs, e);
    end
    clear = 1'b1;
    tick();
    e = {4'd0, 18'h0, 16'h0, 16'h0, 4'h0};
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL clear_t5: got %h want %h", obs, e);
    end
    clear = 1'b0;
    tick();
    e = {4'd1, F_T0, 16'h0, 16'h0, 4'h0};
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL clear_restart: got %h want %h", obs, e);
    end
    mem_ready = 1'b0;
    tick();
    tick();
    mem_ready = 1'b1;
    clear = 1'b1;
    tick();
    e = {4'd0, 18'h0, 16'h0, 16'h0, 4'h0};
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL clear_t2: got %h want %h", obs, e);
    end
    clear = 1'b0;
    run = 1'b0;
  endtask

  task automatic test_muldiv();
    logic [57:0] e [6];
    int ncyc;
    e[0] = {4'd5, B_YIN, 16'h0, 16'h0008, 4'h0};
`ifdef MULDIV_EN
    ncyc = 5;
    e[1] = {4'd6, B_MUL | B_ZLIN | B_ZHIN, 16'h0, 16'h0010, 4'h0};
    e[2] = {4'd7, B_ZLOUT | B_LOIN, 16'h0, 16'h0, 4'h0};
    e[3] = {4'd8, B_ZHOUT | B_HIIN, 16'h0, 16'h0, 4'h0};
    e[4] = {4'd1, F_T0, 16'h0, 16'h0, 4'h0};
`else
    ncyc = 3;
    e[0] = {4'd5, 18'h0, 16'h0, 16'h0, 4'h0};
    e[1] = {4'd9, B_HALT, 16'h0, 16'h0, 4'h0};
    e[2] = {4'd9, B_HALT, 16'h0, 16'h0, 4'h0};
`endif
    e[5] = '0;
    IR = 32'h79A0_0000;
    run = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      tick();
    for (int i = 0; i < ncyc; i++) begin
      tick();
      n_vec++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL mul_c%0d: got %h want %h", i, obs, e[i]);
      end
    end
    clear = 1'b1;
    tick();
    n_vec++;
    if (obs !== e[5]) begin
      n_bad++;
      $display("FAIL mul_clear: got %h want %h", obs, e[5]);
    end
    clear = 1'b0;
    run = 1'b0;
  endtask

  task automatic test_div();
`ifdef MULDIV_EN
    logic [57:0] e;
    IR = 32'h8120_0000;
    run = 1'b1;
    for (int i = 0; i < 6; i++)
      tick();
    e = {4'd6, B_DIV | B_ZLIN | B_ZHIN, 16'h0, 16'h0010, 4'h0};
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL div_t5: got %h want %h", obs, e);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    run = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_shl();
    test_mem_wait();
    test_halt();
    test_clear_mid();
    test_muldiv();
    test_div();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port run, input, 1 bit: start/continue request, sampled in IDLE and at instruction end.
REQ-004 The block SHALL have port IR, input, 32 bits: instruction register contents from datapath; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-005 The block SHALL have port mem_ready, input, 1 bit: memory read-complete handshake.
REQ-006 The block SHALL have ports Rin and Rout, output, 16 bits each: one-hot register load and drive enables.
REQ-007 The block SHALL have 1-bit output strobes PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC and Read: the datapath control strobes of the same name.
REQ-008 The block SHALL have port ALUop, output, 4 bits: ALU operation select.
REQ-009 The block SHALL have ports ALU_MUL and ALU_DIV, output, 1 bit each: multiply and divide enables.
REQ-010 The block SHALL have port halted, output, 1 bit: high while in HALT.
REQ-011 The block SHALL have port state, output, 4 bits: current state code, for debug.

Function
REQ-012 All outputs SHALL be Moore-decoded from state plus IR; any strobe not listed for a state SHALL be 0.
REQ-013 State codes SHALL be IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, T7=8, HALT=9.
REQ-014 IDLE: all strobes 0; next state T0 if run, else IDLE.
REQ-015 T0: PCout, MARin, IncPC, Zlowin.
REQ-016 T1: Zlowout, PCin.
REQ-017 T2: Read, MDRin; remain in T2 while mem_ready=0, go to T3 on the cycle mem_ready=1.
REQ-018 T3: MDRout, IRin.
REQ-019 T4 decodes the new IR. ALU opcodes 0-8: Rout[Rb], Yin. NOP (26): no strobes, next T0 if run, else IDLE. HALT (27) and all undefined opcodes: no strobes, next HALT.
REQ-020 T5 for ALU opcodes: Rout[Rc], Zlowin, ALUop=opcode[3:0] (add=0 ... shl=7 ... 8).
REQ-021 T6 for ALU opcodes: Zlowout, Rin[Ra].
REQ-022 After T6 (ALU) or T7 (mul/div), the next state SHALL be T0 if run, else IDLE.
REQ-023 Rin and Rout SHALL never have more than one bit set, and SHALL never be nonzero in the same cycle.
REQ-024 HALT: halted=1, all strobes 0; exit only via clear.

Reset
REQ-025 clear sampled high SHALL force IDLE on that edge, from any state including mid-fetch or mid-execute; all strobes and halted SHALL be 0 the following cycle.
REQ-026 clear SHALL take priority over run and mem_ready.

Configuration
REQ-027 With MULDIV_EN defined, MUL (opcode 15) and DIV (opcode 16) SHALL execute as follows:
- T4: Rout[Ra], Yin.
- T5: Rout[Rb], ALU_MUL or ALU_DIV, Zlowin, Zhighin.
- T6: Zlowout, LOin.
- T7: Zhighout, HIin.
REQ-028 Without MULDIV_EN, opcodes 15 and 16 SHALL be undefined (T4 goes to HALT); ALU_MUL, ALU_DIV, Zhighin, Zhighout, HIin and LOin SHALL be tied 0.

Verification
REQ-029 shl R7,R0,R4: IR=0x3B820000, mem_ready=1, run=1 -> T4: Rout=0x0001, Yin. T5: Rout=0x0010, ALUop=7, Zlowin. T6: Zlowout, Rin=0x0080. Then T0.
REQ-030 mem_ready held 0 for 3 cycles in T2 -> Read=1 and MDRin=1 for 4 consecutive cycles; T3 follows on the mem_ready=1 cycle.
REQ-031 IR=0xD8000000 (halt) -> HALT after T4, halted=1, run ignored; clear -> IDLE next cycle, halted=0.
REQ-032 clear asserted during T5 -> next cycle state=0 and all strobes 0; with run=1, T0 follows.
REQ-033 MULDIV_EN defined, IR=0x79A00000 (mul R3,R4) -> T4: Rout=0x0008. T5: Rout=0x0010, ALU_MUL, Zlowin, Zhighin. T6: Zlowout, LOin. T7: Zhighout, HIin.
REQ-034 MULDIV_EN undefined, IR=0x79A00000 -> HALT after T4; ALU_MUL is never asserted.
